// File: rtl/gp_cmd_pkg.sv
// Shared types and constants for the GP engine command store.
// The controller state encoding and the command-width bounds live here.
package gp_cmd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_CLEAR = 2'd2
   } state_e;

   localparam int CMD_WORDS_MIN = 1;
   localparam int CMD_WORDS_MAX = 8;
   // Fetch word counter must hold 0..CMD_WORDS_MAX inclusive.
   localparam int FCNT_W = 4;

endpackage

// File: rtl/gp_cmd_ram.sv
// Single-port synchronous RAM: one access per cycle, registered read data.
// Storage is deliberately not reset; software zero-fills it with a clear sweep.
module gp_cmd_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [AW-1:0]         addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_r;

   // Storage array write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[addr] <= wdata;
      end
   end

   // Registered read port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_r <= '0;
      end else begin
         rdata_r <= mem_r[addr];
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/gp_cmd_store.sv
// GP engine command store: slave readback/write port, multi-word command fetch
// for the engine FSM, write locking and a zero-fill sweep over one single-port RAM.
module gp_cmd_store
   import gp_cmd_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256,
   parameter int CMD_WORDS  = 2,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            fetch_req,
   input  logic [AW-1:0]                   fetch_addr,
   output logic                            fetch_valid,
   output logic [CMD_WORDS*DATA_WIDTH-1:0] fetch_cmd,
   input  logic                            cmd_en,
   input  logic [AW-1:0]                   trans_addr,
   input  logic                            slv_o_valid,
   input  logic                            slv_o_rd0_wr1,
   input  logic [DATA_WIDTH-1:0]           slv_o_wr_data,
   output logic                            slv_i_ready,
   output logic                            slv_i_rd_valid,
   output logic [DATA_WIDTH-1:0]           slv_i_rd_data,
   output logic                            slv_i_err,
   input  logic                            wr_lock,
   input  logic                            clear_req,
   output logic                            clear_busy
);

   localparam int CW = CMD_WORDS * DATA_WIDTH;

   state_e                state_r;
   state_e                state_nxt_s;
   logic [FCNT_W-1:0]     fcnt_r;
   logic [AW-1:0]         fetch_base_r;
   logic [AW-1:0]         clr_addr_r;
   logic [CW-1:0]         asm_r;
   logic [CW-1:0]         asm_nxt_s;
   int                    widx_s;

   logic                  ram_we_s;
   logic [AW-1:0]         ram_addr_s;
   logic [DATA_WIDTH-1:0] ram_wdata_s;
   logic [DATA_WIDTH-1:0] ram_rdata_s;

   logic                  slv_acc_s;
   logic                  fetch_done_s;

   logic                  fetch_valid_r;
   logic [CW-1:0]         fetch_cmd_r;
   logic                  rd_valid_r;
   logic                  err_r;
   logic                  clear_busy_r;

   gp_cmd_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (ram_we_s),
      .addr  (ram_addr_s),
      .wdata (ram_wdata_s),
      .rdata (ram_rdata_s)
   );

   assign slv_i_ready = (state_r == ST_IDLE) && !clear_req && !fetch_req;

   // Next-state, arbitration (clear > fetch > slave) and the single RAM access.
   always_comb begin
      state_nxt_s  = state_r;
      ram_we_s     = 1'b0;
      ram_addr_s   = '0;
      ram_wdata_s  = '0;
      slv_acc_s    = 1'b0;
      fetch_done_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (clear_req) begin
               state_nxt_s = ST_CLEAR;
            end else if (fetch_req) begin
               state_nxt_s = ST_FETCH;
            end else if (cmd_en && slv_o_valid) begin
               slv_acc_s   = 1'b1;
               ram_addr_s  = trans_addr;
               ram_we_s    = slv_o_rd0_wr1 && !wr_lock;
               ram_wdata_s = slv_o_wr_data;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            // Address arithmetic is AW bits wide, so it wraps at DEPTH.
            ram_addr_s = fetch_base_r + AW'(fcnt_r);
            if (fcnt_r == FCNT_W'(CMD_WORDS)) begin
               fetch_done_s = 1'b1;
               state_nxt_s  = ST_IDLE;
            end else begin
               state_nxt_s  = ST_FETCH;
            end
         end
         ST_CLEAR: begin
            ram_we_s   = 1'b1;
            ram_addr_s = clr_addr_r;
            if (clr_addr_r == AW'(DEPTH - 1)) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_CLEAR;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Command assembly: read data of word k arrives one cycle after its address.
   always_comb begin
      asm_nxt_s = asm_r;
      widx_s    = int'(fcnt_r) - 1;
      if ((state_r == ST_FETCH) && (fcnt_r != 4'd0)) begin
         asm_nxt_s[widx_s*DATA_WIDTH +: DATA_WIDTH] = ram_rdata_s;
      end else begin
         asm_nxt_s = asm_r;
      end
   end

   // Controller state, fetch/clear counters and assembly buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         fcnt_r       <= '0;
         fetch_base_r <= '0;
         clr_addr_r   <= '0;
         asm_r        <= '0;
      end else begin
         state_r <= state_nxt_s;
         asm_r   <= asm_nxt_s;
         if (state_r == ST_FETCH) begin
            fcnt_r <= fcnt_r + 4'd1;
         end else begin
            fcnt_r <= '0;
         end
         if ((state_r == ST_IDLE) && (state_nxt_s == ST_FETCH)) begin
            fetch_base_r <= fetch_addr;
         end
         if (state_r == ST_CLEAR) begin
            clr_addr_r <= clr_addr_r + AW'(1);
         end else begin
            clr_addr_r <= '0;
         end
      end
   end

   // Registered status pulses and the held command output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_valid_r <= 1'b0;
         fetch_cmd_r   <= '0;
         rd_valid_r    <= 1'b0;
         err_r         <= 1'b0;
         clear_busy_r  <= 1'b0;
      end else begin
         fetch_valid_r <= fetch_done_s;
         if (fetch_done_s) begin
            fetch_cmd_r <= asm_nxt_s;
         end
         rd_valid_r   <= slv_acc_s && !slv_o_rd0_wr1;
         err_r        <= slv_acc_s && slv_o_rd0_wr1 && wr_lock;
         clear_busy_r <= (state_nxt_s == ST_CLEAR);
      end
   end

   assign fetch_valid    = fetch_valid_r;
   assign fetch_cmd      = fetch_cmd_r;
   assign slv_i_rd_valid = rd_valid_r;
   // RAM output is itself a register; gate it so the bus idles at zero.
   assign slv_i_rd_data  = rd_valid_r ? ram_rdata_s : '0;
   assign slv_i_err      = err_r;
   assign clear_busy     = clear_busy_r;

endmodule

// File: tb/tb_gp_cmd_store.sv
// Directed self-checking bench for gp_cmd_store (DEPTH 256, 2-word commands).
module tb_gp_cmd_store;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_req;
   logic [7:0]  fetch_addr;
   logic        fetch_valid;
   logic [63:0] fetch_cmd;
   logic        cmd_en;
   logic [7:0]  trans_addr;
   logic        slv_o_valid;
   logic        slv_o_rd0_wr1;
   logic [31:0] slv_o_wr_data;
   logic        slv_i_ready;
   logic        slv_i_rd_valid;
   logic [31:0] slv_i_rd_data;
   logic        slv_i_err;
   logic        wr_lock;
   logic        clear_req;
   logic        clear_busy;

   int n_assert = 0;
   int n_fail   = 0;

   gp_cmd_store #(
      .DATA_WIDTH (32),
      .DEPTH      (256),
      .CMD_WORDS  (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_req      (fetch_req),
      .fetch_addr     (fetch_addr),
      .fetch_valid    (fetch_valid),
      .fetch_cmd      (fetch_cmd),
      .cmd_en         (cmd_en),
      .trans_addr     (trans_addr),
      .slv_o_valid    (slv_o_valid),
      .slv_o_rd0_wr1  (slv_o_rd0_wr1),
      .slv_o_wr_data  (slv_o_wr_data),
      .slv_i_ready    (slv_i_ready),
      .slv_i_rd_valid (slv_i_rd_valid),
      .slv_i_rd_data  (slv_i_rd_data),
      .slv_i_err      (slv_i_err),
      .wr_lock        (wr_lock),
      .clear_req      (clear_req),
      .clear_busy     (clear_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic slv_idle();
      cmd_en        = 1'b0;
      slv_o_valid   = 1'b0;
      slv_o_rd0_wr1 = 1'b0;
      trans_addr    = 8'd0;
      slv_o_wr_data = 32'd0;
   endtask

   task automatic slv_write(input logic [7:0] a, input logic [31:0] d, input logic exp_err);
      cmd_en = 1'b1; slv_o_valid = 1'b1; slv_o_rd0_wr1 = 1'b1;
      trans_addr = a; slv_o_wr_data = d;
      tick();
      slv_idle();
      chk("wr_err", {63'd0, slv_i_err}, {63'd0, exp_err});
   endtask

   task automatic slv_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
      cmd_en = 1'b1; slv_o_valid = 1'b1; slv_o_rd0_wr1 = 1'b0; trans_addr = a;
      tick();
      slv_idle();
      chk({tag, "_rd_valid"}, {63'd0, slv_i_rd_valid}, 64'd1);
      chk({tag, "_rd_data"}, {32'd0, slv_i_rd_data}, {32'd0, exp});
      tick();
      chk({tag, "_rd_valid_after"}, {63'd0, slv_i_rd_valid}, 64'd0);
      chk({tag, "_rd_data_after"}, {32'd0, slv_i_rd_data}, 64'd0);
   endtask

   task automatic do_fetch(input logic [7:0] a, input logic [63:0] exp, input string tag);
      int lat;
      fetch_req = 1'b1; fetch_addr = a;
      #1;
      chk({tag, "_ready_req"}, {63'd0, slv_i_ready}, 64'd0);
      tick();
      lat = 0;
      while (!fetch_valid && lat < 20) begin
         chk({tag, "_ready_busy"}, {63'd0, slv_i_ready}, 64'd0);
         tick();
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'd3);
      chk({tag, "_cmd"}, fetch_cmd, exp);
      fetch_req = 1'b0;
      #1;
      chk({tag, "_ready_done"}, {63'd0, slv_i_ready}, 64'd1);
      tick();
      chk({tag, "_valid_pulse"}, {63'd0, fetch_valid}, 64'd0);
      chk({tag, "_cmd_hold"}, fetch_cmd, exp);
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = 8'd0;
      wr_lock = 1'b0; clear_req = 1'b0;
      slv_idle();
      #12;
      chk("rst_fetch_valid", {63'd0, fetch_valid}, 64'd0);
      chk("rst_fetch_cmd", fetch_cmd, 64'd0);
      chk("rst_rd_valid", {63'd0, slv_i_rd_valid}, 64'd0);
      chk("rst_rd_data", {32'd0, slv_i_rd_data}, 64'd0);
      chk("rst_err", {63'd0, slv_i_err}, 64'd0);
      chk("rst_clear_busy", {63'd0, clear_busy}, 64'd0);
      rst_n = 1'b1;
      tick();

      // Zero-fill sweep
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      cnt = 0;
      while (clear_busy && cnt < 1000) begin
         if (cnt == 100) begin
            chk("clear_ready", {63'd0, slv_i_ready}, 64'd0);
         end
         cnt++;
         tick();
      end
      chk("clear_cycles", 64'(cnt), 64'd256);
      slv_read(8'd0, 32'h0000_0000, "clr0");
      slv_read(8'd128, 32'h0000_0000, "clr128");
      slv_read(8'd255, 32'h0000_0000, "clr255");

      // Basic two-word fetch
      slv_write(8'd5, 32'hDEAD_BEEF, 1'b0);
      slv_write(8'd6, 32'h1234_5678, 1'b0);
      do_fetch(8'd5, 64'h1234_5678_DEAD_BEEF, "f5");

      // Address wrap at DEPTH
      slv_write(8'd255, 32'h0000_000A, 1'b0);
      slv_write(8'd0, 32'h0000_000B, 1'b0);
      do_fetch(8'd255, 64'h0000_000B_0000_000A, "fwrap");

      // Write lock
      slv_write(8'd10, 32'h5555_0101, 1'b0);
      wr_lock = 1'b1;
      slv_write(8'd10, 32'hFFFF_FFFF, 1'b1);
      tick();
      chk("err_pulse_end", {63'd0, slv_i_err}, 64'd0);
      slv_read(8'd10, 32'h5555_0101, "locked10");
      wr_lock = 1'b0;

      // Fetch and slave write requested together: fetch wins, write follows
      cmd_en = 1'b1; slv_o_valid = 1'b1; slv_o_rd0_wr1 = 1'b1;
      trans_addr = 8'd20; slv_o_wr_data = 32'h0000_0077;
      do_fetch(8'd5, 64'h1234_5678_DEAD_BEEF, "fcoll");
      slv_idle();
      slv_read(8'd20, 32'h0000_0077, "coll20");

      // Reset in the middle of a fetch
      fetch_req = 1'b1; fetch_addr = 8'd255;
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      fetch_req = 1'b0;
      #1;
      chk("mid_rst_fetch_valid", {63'd0, fetch_valid}, 64'd0);
      chk("mid_rst_fetch_cmd", fetch_cmd, 64'd0);
      chk("mid_rst_rd_data", {32'd0, slv_i_rd_data}, 64'd0);
      chk("mid_rst_clear_busy", {63'd0, clear_busy}, 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", {63'd0, slv_i_ready}, 64'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_no_valid", {63'd0, fetch_valid}, 64'd0);
      end
      slv_read(8'd6, 32'h1234_5678, "post_rst6");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/gp_cmd_store.md
Name: gp_cmd_store

Overview:
- Second-generation command store for the GP engine.
- Holds DEPTH words of DATA_WIDTH, written and read back over the AHB-slave valid/ready port, selected by the address decoder.
- Serves multi-word commands (CMD_WORDS words) to the engine FSM through a request/valid fetch port with defined latency.
- Adds write locking with error response, a hardware clear sweep, and fixed arbitration, all over a single-port RAM.

Parameters:
DATA_WIDTH, 32, width of one stored word and of the slave data bus
DEPTH, 256, number of words; must be a power of two, at least 4
CMD_WORDS, 2, words per fetched command, 1..8
AW, $clog2(DEPTH), word-address width (derived; not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
fetch_req  in  1  FSM command-fetch request (level)
fetch_addr  in  AW  word index of first command word
fetch_valid  out  1  one-cycle pulse: fetch_cmd valid
fetch_cmd  out  CMD_WORDS*DATA_WIDTH  assembled command
cmd_en  in  1  address-decoder select
trans_addr  in  AW  slave word index
slv_o_valid  in  1  slave transaction valid
slv_o_rd0_wr1  in  1  1 = write, 0 = readback
slv_o_wr_data  in  DATA_WIDTH  write data
slv_i_ready  out  1  store accepts slave transaction this cycle
slv_i_rd_valid  out  1  one-cycle pulse: readback data valid
slv_i_rd_data  out  DATA_WIDTH  readback data
slv_i_err  out  1  one-cycle pulse: write rejected (locked)
wr_lock  in  1  1 = slave writes rejected
clear_req  in  1  start zero-fill sweep (sampled in IDLE)
clear_busy  out  1  sweep in progress

Behaviour:
- Reset: state IDLE. fetch_valid, fetch_cmd, slv_i_rd_valid, slv_i_rd_data, slv_i_err, clear_busy all 0. RAM contents not reset; software issues clear_req.
- States: IDLE, FETCH, CLEAR.
- Priority in IDLE: clear_req > fetch_req > slave transaction.
- slv_i_ready is combinational: (state==IDLE) && !clear_req && !fetch_req.
- Slave handshake: accepted on a clock edge with cmd_en && slv_o_valid && slv_i_ready.
  - Write, wr_lock=0: RAM[trans_addr] is updated at that edge.
  - Write, wr_lock=1: RAM unchanged; slv_i_err pulses on the next cycle.
  - Readback: slv_i_rd_valid pulses and slv_i_rd_data = RAM[trans_addr] on the next cycle (latency 1); rd_data returns to 0 afterwards.
- FETCH:
  - Entered from IDLE on fetch_req with no clear_req; fetch_addr is latched.
  - Reads word (addr+k) mod DEPTH for k = 0..CMD_WORDS-1, one per cycle; address wraps at DEPTH.
  - Word k is placed at fetch_cmd[k*DATA_WIDTH +: DATA_WIDTH].
  - fetch_valid pulses exactly CMD_WORDS+1 cycles after the acceptance edge, then the block returns to IDLE.
  - fetch_cmd holds its value until the next fetch completes.
  - fetch_req still high in the fetch_valid cycle starts a new fetch from IDLE on the following edge; the FSM drops the request on fetch_valid.
- CLEAR:
  - Writes 0 to addresses 0..DEPTH-1, one per cycle; clear_busy=1 throughout.
  - Takes DEPTH cycles, then returns to IDLE.
  - wr_lock is ignored by the sweep.
  - fetch_req and slave traffic stall (ready=0) during the sweep.
- A fetch or clear is never aborted by new requests. Asserting rst_n low mid-operation returns to IDLE immediately with all outputs at reset values; a partial clear leaves the remaining words unchanged.
- One RAM access per cycle, always; no read/write collision is possible.

Decomposition:
- Package gp_cmd_pkg: state enum (IDLE, FETCH, CLEAR) and CMD_WORDS bound constants.
- Sub-module gp_cmd_ram: single-port synchronous RAM (DEPTH x DATA_WIDTH, registered read, write-enable). It is instantiated once; the controller FSM, arbitration and command assembly stay in gp_cmd_store.

Test Plan:
- Reset, then clear_req for 1 cycle -> clear_busy high for 256 cycles; readback of addresses 0, 128 and 255 returns 0x0000_0000.
- Write 0xDEAD_BEEF to 5 and 0x1234_5678 to 6, then fetch_addr=5 -> fetch_valid 3 cycles after accept, fetch_cmd=0x1234_5678_DEAD_BEEF.
- Wrap: write 0xA to 255 and 0xB to 0, then fetch_addr=255 -> fetch_cmd=0x0000_000B_0000_000A.
- wr_lock=1, write 0xFFFF_FFFF to 10 -> slv_i_err pulse 1 cycle later; readback of 10 is still the old value with slv_i_rd_valid pulse.
- Same cycle fetch_req and slave write -> slv_i_ready=0; fetch completes first, write is accepted in the first IDLE cycle after fetch_valid.
- Assert rst_n low 2 cycles into FETCH -> fetch_valid never pulses; outputs 0; block returns to IDLE and slv_i_ready=1 on release.
